// File: rtl/act_pkg.sv
// Shared definitions for the activation engine: activation mode encodings,
// the map-sequencing FSM states and a small width helper.
package act_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_RELU   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_RELU6  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Leaky slope is 1/8, implemented as an arithmetic right shift.
  localparam int LEAKY_SHIFT = 3;

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_lane.sv
// Single-pixel combinational activation: bypass, ReLU, leaky ReLU (x/8 for
// negatives, rounded toward minus infinity) and ReLU6 with a fixed ceiling.
// Every result is either x itself, zero, the ceiling, or x shifted right,
// so the output always fits in DATA_WIDTH.
module relu_lane
  import act_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int CLIP_VAL   = 1536
) (
  input  mode_t                         mode,
  input  logic signed [DATA_WIDTH-1:0]  x,
  output logic signed [DATA_WIDTH-1:0]  y
);

  localparam logic signed [DATA_WIDTH-1:0] CLIP = DATA_WIDTH'(CLIP_VAL);

  logic neg;

  assign neg = x[DATA_WIDTH-1];

  // Select the activation result for the requested mode.
  always_comb begin
    y = x;
    case (mode)
      MODE_BYPASS: y = x;
      MODE_RELU:   y = neg ? '0 : x;
      MODE_LEAKY:  y = neg ? (x >>> LEAKY_SHIFT) : x;
      MODE_RELU6: begin
        if (neg) begin
          y = '0;
        end else if (x > CLIP) begin
          y = CLIP;
        end else begin
          y = x;
        end
      end
      default:     y = x;
    endcase
  end

endmodule

// File: rtl/relu_engine.sv
// Streaming activation engine for one feature map of D channels, each
// W*H pixels, delivered LANES pixels per beat. A single registered output
// stage gives one cycle of latency and full throughput; the FSM tracks the
// map so the activation mode stays fixed for a whole map and the final beat
// is followed by a one-cycle done pulse.
module relu_engine
  import act_pkg::*;
#(
  parameter int W          = 28,
  parameter int H          = 28,
  parameter int D          = 6,
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int FRAC_BITS  = 8,
  parameter int CLIP_VAL   = 6 << FRAC_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [1:0]                    cfg_mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [clog2_min1(D)-1:0]      out_ch,
  output logic                          out_last_ch,
  output logic                          out_last_map,
  output logic                          busy,
  output logic                          done
);

  localparam int BEATS_PER_CH = (W * H) / LANES;
  localparam int BEAT_W       = clog2_min1(BEATS_PER_CH);
  localparam int CH_W         = clog2_min1(D);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS_PER_CH - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(D - 1);

  generate
    if (((W * H) % LANES) != 0) begin : g_bad_lanes
      $error("relu_engine: W*H must be a multiple of LANES");
    end
    if ((CLIP_VAL <= 0) || (64'(CLIP_VAL) >= (64'd1 << (DATA_WIDTH - 1)))) begin : g_bad_clip
      $error("relu_engine: CLIP_VAL must be positive and fit in DATA_WIDTH-1 bits");
    end
  endgenerate

  state_t                     state;
  state_t                     state_next;
  mode_t                      mode_q;
  mode_t                      active_mode;
  logic [BEAT_W-1:0]          beat_cnt;
  logic [CH_W-1:0]            ch_cnt;
  logic [LANES*DATA_WIDTH-1:0] lane_y;
  logic                       in_fire;
  logic                       out_fire;
  logic                       last_beat_of_ch;
  logic                       final_beat;

  assign in_fire         = in_valid && in_ready;
  assign out_fire        = out_valid && out_ready;
  assign last_beat_of_ch = (beat_cnt == LAST_BEAT);
  assign final_beat      = last_beat_of_ch && (ch_cnt == LAST_CH);

  // The first beat of a map uses cfg_mode directly; later beats use the
  // copy captured with that first beat.
  assign active_mode = (state == IDLE) ? mode_t'(cfg_mode) : mode_q;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      relu_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .CLIP_VAL   (CLIP_VAL)
      ) u_lane (
        .mode (active_mode),
        .x    (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
        .y    (lane_y[k*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // Map FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: a single-beat map goes straight from IDLE to DRAIN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_fire) begin
          state_next = final_beat ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (in_fire && final_beat) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: input is closed while the last beat drains and during the
  // done cycle, so a new map never overlaps the previous one's completion.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !done && (!out_valid || out_ready);
        busy     = 1'b0;
      end
      RUN: begin
        in_ready = !out_valid || out_ready;
        busy     = 1'b1;
      end
      DRAIN: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // Capture the activation mode with the first beat of each map.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= MODE_BYPASS;
    end else if (in_fire && (state == IDLE)) begin
      mode_q <= mode_t'(cfg_mode);
    end
  end

  // Beat and channel position of the next beat to be accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      ch_cnt   <= '0;
    end else if (in_fire) begin
      if (last_beat_of_ch) begin
        beat_cnt <= '0;
        ch_cnt   <= (ch_cnt == LAST_CH) ? '0 : ch_cnt + CH_W'(1);
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // Registered output stage; holds its contents while stalled downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_ch       <= '0;
      out_last_ch  <= 1'b0;
      out_last_map <= 1'b0;
    end else if (in_fire) begin
      out_valid    <= 1'b1;
      out_data     <= lane_y;
      out_ch       <= ch_cnt;
      out_last_ch  <= last_beat_of_ch;
      out_last_map <= final_beat;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Pulse done once the final beat of the map leaves the output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= (state == DRAIN) && out_fire;
    end
  end

endmodule
